// File: rtl/cmda_cmd_seq.sv
// Command sequencer: expands upstream command words into one command slot plus NOP pause
// cycles, driving 2:1 SDR pin pairs and a shared tristate for the CMD/address bus.
module cmda_cmd_seq #(
   parameter int ADDRESS_NUMBER = 15,
   parameter int PAUSE_BITS     = 8
) (
   input  logic                                 clk_div,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic [ADDRESS_NUMBER+PAUSE_BITS+8:0] cmd_data,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   output logic [2*ADDRESS_NUMBER-1:0]          addr_din,
   output logic [5:0]                           ba_din,
   output logic [1:0]                           ras_din,
   output logic [1:0]                           cas_din,
   output logic [1:0]                           we_din,
   output logic [1:0]                           cke_din,
   output logic [1:0]                           odt_din,
   output logic                                 cmda_tri,
   output logic                                 busy,
   output logic                                 done
);

   localparam int A  = ADDRESS_NUMBER;
   localparam int PB = PAUSE_BITS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PB-1:0]   cnt_q, cnt_d;
   logic [PB-1:0]   pause_q, pause_d;
   logic            last_q, last_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            tri_q, tri_d;
   logic [A-1:0]    addr_q, addr_d;
   logic [2:0]      ba_q, ba_d;
   logic            ras_q, ras_d;
   logic            cas_q, cas_d;
   logic            we_q, we_d;
   logic            cke_q, cke_d;
   logic            odt_q, odt_d;

   logic [A-1:0]    w_addr;
   logic [2:0]      w_ba;
   logic            w_ras, w_cas, w_we, w_odt, w_cke, w_last;
   logic [PB-1:0]   w_pause;
   logic            free;
   logic            accept;

   assign w_addr  = cmd_data[A-1:0];
   assign w_ba    = cmd_data[A+2:A];
   assign w_ras   = cmd_data[A+3];
   assign w_cas   = cmd_data[A+4];
   assign w_we    = cmd_data[A+5];
   assign w_odt   = cmd_data[A+6];
   assign w_cke   = cmd_data[A+7];
   assign w_pause = cmd_data[A+8+PB-1:A+8];
   assign w_last  = cmd_data[A+8+PB];

   // A new word may enter only where the current command's spacing has run out; reset forces ready low.
   assign free = (state_q == ST_IDLE)
               | ((state_q == ST_CMD)  & (pause_q == '0))
               | ((state_q == ST_WAIT) & (cnt_q == PB'(1)));
   assign cmd_ready = rst & en & free & ~(last_q & (state_q != ST_IDLE));
   assign accept    = cmd_valid & cmd_ready;

   // Next-state, pause counting, busy/done and tristate control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pause_d = pause_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      addr_d  = addr_q;
      ba_d    = ba_q;
      ras_d   = 1'b1;
      cas_d   = 1'b1;
      we_d    = 1'b1;
      cke_d   = cke_q;
      odt_d   = odt_q;

      case (state_q)
         ST_IDLE: begin
            busy_d = busy_q & en;
         end
         ST_CMD: begin
            if (pause_q != '0) begin
               state_d = ST_WAIT;
               cnt_d   = pause_q;
            end else if (last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
               busy_d  = busy_q & en;
            end
         end
         ST_WAIT: begin
            if (cnt_q == PB'(1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (last_q) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end else begin
                  busy_d = busy_q & en;
               end
            end else begin
               cnt_d = cnt_q - PB'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase

      // An accepted word overrides the idle fallthrough of whichever state made room for it.
      if (accept) begin
         state_d = ST_CMD;
         pause_d = w_pause;
         last_d  = w_last;
         busy_d  = 1'b1;
         addr_d  = w_addr;
         ba_d    = w_ba;
         ras_d   = w_ras;
         cas_d   = w_cas;
         we_d    = w_we;
         cke_d   = w_cke;
         odt_d   = w_odt;
      end else begin
         pause_d = pause_q;
      end

      if (en) begin
         tri_d = 1'b0;
      end else if ((state_q == ST_IDLE) & ~busy_q) begin
         tri_d = 1'b1;
      end else begin
         tri_d = tri_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_div or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pause_q <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tri_q   <= 1'b1;
         addr_q  <= '0;
         ba_q    <= 3'b000;
         ras_q   <= 1'b1;
         cas_q   <= 1'b1;
         we_q    <= 1'b1;
         cke_q   <= 1'b0;
         odt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pause_q <= pause_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tri_q   <= tri_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         ras_q   <= ras_d;
         cas_q   <= cas_d;
         we_q    <= we_d;
         cke_q   <= cke_d;
         odt_q   <= odt_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < A; gi++) begin : g_addr
         assign addr_din[2*gi +: 2] = {2{addr_q[gi]}};
      end
      for (gi = 0; gi < 3; gi++) begin : g_ba
         assign ba_din[2*gi +: 2] = {2{ba_q[gi]}};
      end
   endgenerate

   // Command only in slot0; slot1 is always NOP.
   assign ras_din  = {1'b1, ras_q};
   assign cas_din  = {1'b1, cas_q};
   assign we_din   = {1'b1, we_q};
   assign cke_din  = {2{cke_q}};
   assign odt_din  = {2{odt_q}};
   assign cmda_tri = tri_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
